// File: rtl/proj_pkg.sv
// proj_pkg: shared widths, FM controller state type and bit-rank helpers
// Contents:
//   FM_BUFFER_SIZE  default number of sketch slots
//   FM_MAP_W        bitmap width per slot
//   HASH_W          hash word width
//   fm_state_t      IDLE / SCAN / DONE
//   lowest_set_idx  rank of a hash (lowest set bit, saturated to w-1)
//   lowest_zero_idx FM estimate R of a bitmap (lowest zero bit, w if all ones)
package proj_pkg;
  localparam int FM_BUFFER_SIZE = 16;
  localparam int FM_MAP_W = 32;
  localparam int HASH_W = 32;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} fm_state_t;
  // Scanning from the top down leaves the lowest hit; no hit below w-1 saturates.
  function automatic int lowest_set_idx(input logic [63:0] v, input int w);
    lowest_set_idx = w - 1;
    for (int i = w - 2; i >= 0; i--)
      if (v[6'(i)]) lowest_set_idx = i;
  endfunction
  function automatic int lowest_zero_idx(input logic [63:0] v, input int w);
    lowest_zero_idx = w;
    for (int i = w - 1; i >= 0; i--)
      if (!v[6'(i)]) lowest_zero_idx = i;
  endfunction
endpackage

// File: rtl/proj_fm_sketch_ctrl_if.sv
// proj_fm_sketch_ctrl_if: hash input, flush request and estimate output bundle
// Signals:
//   in_hash/in_hash_valid/out_hash_ready   hash stream handshake
//   in_flush                               start of readout scan
//   out_est_valid/in_est_ready             estimate handshake
//   out_est_slot/out_est_r                 slot number and its R
//   out_done/out_sum                       scan-complete pulse and sum of R
// Modports: master drives the in_* signals, slave (the controller) drives out_*.
interface proj_fm_sketch_ctrl_if #(
  parameter int NUM_SLOTS = proj_pkg::FM_BUFFER_SIZE,
  parameter int MAP_W = proj_pkg::FM_MAP_W,
  parameter int HASH_W = proj_pkg::HASH_W
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int R_W = $clog2(MAP_W + 1);
  localparam int SUM_W = R_W + IDX_W;
  logic [HASH_W-1:0] in_hash;
  logic in_hash_valid;
  logic out_hash_ready;
  logic in_flush;
  logic out_est_valid;
  logic in_est_ready;
  logic [IDX_W-1:0] out_est_slot;
  logic [R_W-1:0] out_est_r;
  logic out_done;
  logic [SUM_W-1:0] out_sum;
  modport master (
    output in_hash, in_hash_valid, in_flush, in_est_ready,
    input out_hash_ready, out_est_valid, out_est_slot, out_est_r, out_done, out_sum
  );
  modport slave (
    input in_hash, in_hash_valid, in_flush, in_est_ready,
    output out_hash_ready, out_est_valid, out_est_slot, out_est_r, out_done, out_sum
  );
endinterface

// File: rtl/proj_fm_bitmap_ram.sv
// proj_fm_bitmap_ram: NUM_SLOTS x MAP_W sketch bitmap register array
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low clear of all slots
//   i_set_en/i_set_idx/i_set_mask  OR a mask into one slot
//   i_clr_en/i_clr_idx     zero one slot (wins over a set to the same slot)
//   i_rd_idx/o_rd_data     combinational read port
module proj_fm_bitmap_ram #(
  parameter int NUM_SLOTS = 4,
  parameter int MAP_W = 8,
  localparam int IDX_W = $clog2(NUM_SLOTS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_set_en,
  input  logic [IDX_W-1:0] i_set_idx,
  input  logic [MAP_W-1:0] i_set_mask,
  input  logic             i_clr_en,
  input  logic [IDX_W-1:0] i_clr_idx,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [MAP_W-1:0] o_rd_data
);
  logic [MAP_W-1:0] r_mem [NUM_SLOTS];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_mem <= '{default: '0};
    else begin
      if (i_set_en) r_mem[i_set_idx] <= r_mem[i_set_idx] | i_set_mask;
      if (i_clr_en) r_mem[i_clr_idx] <= '0;
    end
  assign o_rd_data = r_mem[i_rd_idx];
endmodule

// File: rtl/proj_fm_sketch_ctrl.sv
// proj_fm_sketch_ctrl: Flajolet-Martin sketch bitmap controller
// Ports:
//   in_clk    clock, rising edge
//   in_rst_n  asynchronous active-low reset
//   bus       proj_fm_sketch_ctrl_if.slave: hash stream in, flush request,
//             per-slot estimate stream out, done pulse with sum of R
module proj_fm_sketch_ctrl #(
  parameter int NUM_SLOTS = proj_pkg::FM_BUFFER_SIZE,
  parameter int MAP_W = proj_pkg::FM_MAP_W,
  parameter int HASH_W = proj_pkg::HASH_W
) (
  input logic in_clk,
  input logic in_rst_n,
  proj_fm_sketch_ctrl_if.slave bus
);
  import proj_pkg::*;
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int R_W = $clog2(MAP_W + 1);
  localparam int SUM_W = R_W + IDX_W;
  fm_state_t        r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_scan_idx;
  logic [SUM_W-1:0] r_acc;
  logic [HASH_W-1:0] w_hash;
  logic [MAP_W-1:0] w_set_mask;
  logic [MAP_W-1:0] w_rd_data;
  logic [R_W-1:0]   w_r;
  logic             w_accept;
  logic             w_est_accept;
  assign w_hash = bus.in_hash;
  assign w_accept = bus.in_hash_valid && r_state == IDLE;
  assign w_est_accept = bus.in_est_ready && r_state == SCAN;
  assign w_set_mask = MAP_W'(1) << lowest_set_idx(64'(w_hash), MAP_W);
  assign w_r = R_W'(lowest_zero_idx(64'(w_rd_data), MAP_W));
  // The scan reads and clears the same slot, so one index serves both ports.
  proj_fm_bitmap_ram #(.NUM_SLOTS(NUM_SLOTS), .MAP_W(MAP_W)) u_ram (
    .i_clk      (in_clk),
    .i_rst_n    (in_rst_n),
    .i_set_en   (w_accept),
    .i_set_idx  (r_ptr),
    .i_set_mask (w_set_mask),
    .i_clr_en   (w_est_accept),
    .i_clr_idx  (r_scan_idx),
    .i_rd_idx   (r_scan_idx),
    .o_rd_data  (w_rd_data)
  );
  // NUM_SLOTS is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_scan_idx <= '0;
      r_acc <= '0;
    end else
      case (r_state)
        IDLE: begin
          if (w_accept) r_ptr <= r_ptr + IDX_W'(1);
          if (bus.in_flush) begin
            r_state <= SCAN;
            r_scan_idx <= '0;
            r_acc <= '0;
          end
        end
        SCAN:
          if (w_est_accept) begin
            r_acc <= r_acc + SUM_W'(w_r);
            r_scan_idx <= r_scan_idx + IDX_W'(1);
            if (r_scan_idx == IDX_W'(NUM_SLOTS - 1)) r_state <= DONE;
          end
        DONE: begin
          r_ptr <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
  assign bus.out_hash_ready = r_state == IDLE;
  assign bus.out_est_valid = r_state == SCAN;
  assign bus.out_est_slot = r_scan_idx;
  assign bus.out_est_r = r_state == SCAN ? w_r : '0;
  assign bus.out_done = r_state == DONE;
  // The accumulator is only restarted by a flush, so it holds the last sum.
  assign bus.out_sum = r_acc;
endmodule

// File: tb/tb_proj_fm_sketch_ctrl.sv
// tb_proj_fm_sketch_ctrl: directed plus randomized check of the FM sketch controller
module tb_proj_fm_sketch_ctrl;
  localparam int NS = 4;
  localparam int MW = 8;
  localparam int HW = 8;
  logic in_clk = 1'b0;
  logic in_rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int bm [NS];
  int ptr = 0;
  proj_fm_sketch_ctrl_if #(.NUM_SLOTS(NS), .MAP_W(MW), .HASH_W(HW)) bus ();
  proj_fm_sketch_ctrl #(.NUM_SLOTS(NS), .MAP_W(MW), .HASH_W(HW)) dut (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .bus      (bus)
  );
  always #5 in_clk = ~in_clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  // rank: position of lowest one, capped at MW-1
  function automatic int rho_of(input int h);
    int k = 0;
    while (k < MW - 1 && ((h >> k) & 1) == 0) k++;
    return k;
  endfunction
  // FM estimate: number of consecutive ones from bit 0
  function automatic int r_of(input int b);
    int k = 0;
    while (k < MW && ((b >> k) & 1) == 1) k++;
    return k;
  endfunction
  task automatic step;
    @(posedge in_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset;
    foreach (bm[i]) bm[i] = 0;
    ptr = 0;
  endtask
  task automatic model_accept(input int h);
    bm[ptr] |= 1 << rho_of(h);
    ptr = (ptr + 1) % NS;
  endtask
  task automatic send(input int h);
    bus.in_hash = 8'(h);
    bus.in_hash_valid = 1'b1;
    chk("hash_ready", 32'(bus.out_hash_ready), 1);
    chk("idle_est_valid", 32'(bus.out_est_valid), 0);
    model_accept(h);
    step();
    bus.in_hash_valid = 1'b0;
  endtask
  task automatic scan(input bit with_hash, input int h, input int bp_slot, input int bp_n);
    int acc = 0;
    int r;
    int hold;
    bus.in_flush = 1'b1;
    if (with_hash) begin
      bus.in_hash = 8'(h);
      bus.in_hash_valid = 1'b1;
      model_accept(h);
    end
    step();
    bus.in_flush = 1'b0;
    bus.in_hash_valid = 1'b0;
    for (int s = 0; s < NS; s++) begin
      r = r_of(bm[s]);
      hold = (s == bp_slot) ? bp_n : 0;
      for (int c = 0; c <= hold; c++) begin
        // flushes and hashes offered during the scan must be ignored
        bus.in_flush = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.in_hash_valid = 1'($urandom_range(0, 1));
        bus.in_hash = 8'($urandom);
        chk("est_valid", 32'(bus.out_est_valid), 1);
        chk("est_slot", 32'(bus.out_est_slot), 32'(s));
        chk("est_r", 32'(bus.out_est_r), 32'(r));
        chk("scan_hash_ready", 32'(bus.out_hash_ready), 0);
        chk("scan_done", 32'(bus.out_done), 0);
        bus.in_est_ready = (c == hold);
        step();
      end
      acc += r;
      bm[s] = 0;
    end
    bus.in_est_ready = 1'b0;
    bus.in_flush = 1'($urandom_range(0, 1));
    chk("done", 32'(bus.out_done), 1);
    chk("sum", 32'(bus.out_sum), 32'(acc));
    chk("done_est_valid", 32'(bus.out_est_valid), 0);
    chk("done_hash_ready", 32'(bus.out_hash_ready), 0);
    step();
    bus.in_flush = 1'b0;
    bus.in_hash_valid = 1'b0;
    ptr = 0;
    chk("done_pulse_end", 32'(bus.out_done), 0);
    chk("post_hash_ready", 32'(bus.out_hash_ready), 1);
    chk("sum_hold", 32'(bus.out_sum), 32'(acc));
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hash_ready"}, 32'(bus.out_hash_ready), 1);
    chk({tag, "_est_valid"}, 32'(bus.out_est_valid), 0);
    chk({tag, "_done"}, 32'(bus.out_done), 0);
    chk({tag, "_sum"}, 32'(bus.out_sum), 0);
    chk({tag, "_est_slot"}, 32'(bus.out_est_slot), 0);
    chk({tag, "_est_r"}, 32'(bus.out_est_r), 0);
  endtask
  initial begin
    bus.in_hash = '0;
    bus.in_hash_valid = 1'b0;
    bus.in_flush = 1'b0;
    bus.in_est_ready = 1'b0;
    model_reset();
    // reset, then an immediate flush of empty bitmaps
    repeat (2) step();
    chk_reset_outputs("in_reset");
    in_rst_n = 1'b1;
    step();
    chk_reset_outputs("after_reset");
    scan(1'b0, 0, -1, 0);
    // rank and pointer wrap
    repeat (4) send(8'h01);
    repeat (4) send(8'h02);
    scan(1'b0, 0, -1, 0);
    // saturation: zero hash and top bit both land on bit MW-1
    send(8'h00);
    repeat (3) send(8'h10);
    send(8'h80);
    scan(1'b0, 0, -1, 0);
    // fill slot 1 completely, backpressure 3 cycles on slot 1
    for (int k = 0; k < MW; k++) begin
      send(8'h00);
      send(1 << k);
      send(8'h00);
      send(8'h00);
    end
    scan(1'b0, 0, 1, 3);
    // flush together with an accepted hash
    scan(1'b1, 8'h04, -1, 0);
    repeat (4) send(8'h01);
    send(8'h02);
    scan(1'b1, 8'h04, 2, 1);
    // reset during a scan
    send(8'h01);
    send(8'h03);
    bus.in_flush = 1'b1;
    step();
    bus.in_flush = 1'b0;
    bus.in_est_ready = 1'b1;
    repeat (2) step();
    bus.in_est_ready = 1'b0;
    #2;
    in_rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs("mid_scan_reset");
    repeat (2) begin
      step();
      chk("reset_no_done", 32'(bus.out_done), 0);
    end
    in_rst_n = 1'b1;
    step();
    chk_reset_outputs("after_mid_reset");
    scan(1'b0, 0, -1, 0);
    send(8'h01);
    scan(1'b0, 0, -1, 0);
    // randomized traffic against the model
    for (int it = 0; it < 25; it++) begin
      int n = $urandom_range(0, 12);
      for (int j = 0; j < n; j++) begin
        int h = $urandom_range(0, 2) == 0 ? 1 << $urandom_range(0, MW - 1) : int'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) begin
          step();
          chk("gap_hash_ready", 32'(bus.out_hash_ready), 1);
        end
        send(h);
      end
      scan(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/proj_fm_sketch_ctrl.md
Name: proj_fm_sketch_ctrl

Overview:
Controller for the Flajolet-Martin (FM) sketch bitmap buffer of the Minhash datapath.
- Accepts a stream of hash words and assigns each to a sketch slot using a round-robin slot index that wraps at NUM_SLOTS.
- Sets the rank bit of that hash in the slot's bitmap.
- On request, sequences a scan that reads out and clears every slot. Each slot yields its FM estimate R, and the sum of all R values is reported at the end.
- Sits between the hash pipeline and the downstream estimator.

Parameters:
NUM_SLOTS, proj_pkg::FM_BUFFER_SIZE, number of sketch slots; power of two, >=2.
MAP_W, proj_pkg::FM_MAP_W (32), bitmap width per slot in bits.
HASH_W, proj_pkg::HASH_W (32), input hash width in bits.

Ports:
in_clk  input  1  clock; all state updates on rising edge.
in_rst_n  input  1  asynchronous active-low reset.
in_hash  input  HASH_W  hash word.
in_hash_valid  input  1  in_hash is valid.
out_hash_ready  output  1  controller accepts a hash this cycle.
in_flush  input  1  single-cycle request to start the readout scan.
out_est_valid  output  1  estimate output is valid.
in_est_ready  input  1  downstream accepts the estimate.
out_est_slot  output  IDX_W  slot number of the current estimate.
out_est_r  output  R_W  FM estimate R of the current slot.
out_done  output  1  one-cycle pulse when the scan completes.
out_sum  output  SUM_W  sum of R over all slots; valid while out_done=1.

Behaviour:
Widths:
- IDX_W = $clog2(NUM_SLOTS).
- R_W = $clog2(MAP_W+1).
- SUM_W = R_W + IDX_W.

Reset (asynchronous, in_rst_n=0):
- All bitmaps cleared to 0; slot pointer = 0; accumulator = 0; state = IDLE.
- out_est_valid = 0, out_done = 0, out_sum = 0, out_est_slot = 0, out_est_r = 0.
- out_hash_ready = 1 (it is combinational from state == IDLE).

States:
IDLE:
- out_hash_ready = 1.
- A hash is accepted when in_hash_valid & out_hash_ready.
- rho = index of the lowest set bit of in_hash, saturated to MAP_W-1. in_hash == 0 also gives rho = MAP_W-1.
- At the accepting edge: bitmap[ptr] |= (1 << rho), and ptr = (ptr+1) mod NUM_SLOTS.
- Throughput is one hash per cycle. Updates are visible to the scan on the next cycle.
- in_flush=1 moves the state to SCAN and sets scan index = 0 and accumulator = 0.
- If in_flush and an accepted hash occur in the same cycle, the hash is applied first and is included in the scan.

SCAN:
- out_hash_ready = 0.
- out_est_valid = 1, out_est_slot = scan index.
- out_est_r = index of the lowest zero bit of bitmap[scan index]; equals MAP_W if the bitmap is all ones.
- Outputs hold stable until in_est_ready = 1.
- On the accepting edge: bitmap[scan index] is cleared, the accumulator adds out_est_r, and the scan index increments.
- After slot NUM_SLOTS-1 is accepted, the state moves to DONE.

DONE:
- Lasts exactly one cycle: out_done = 1, out_sum = final accumulator, out_est_valid = 0.
- ptr is reset to 0, then the state returns to IDLE.
- out_sum holds its value until the next scan starts.

Other rules:
- in_flush is ignored in SCAN and DONE.
- in_est_ready is ignored outside SCAN.
- Reset asserted mid-scan aborts the scan immediately to the reset state. No out_done is produced.

Decomposition:
proj_pkg gains:
- FM_MAP_W, HASH_W.
- typedef fm_state_t {IDLE, SCAN, DONE}.
- A function for lowest-set-bit index and a function for lowest-zero-bit index; both are shared with the estimator.

Sub-module proj_fm_bitmap_ram:
- NUM_SLOTS x MAP_W register array.
- One combinational read port and one write port with set-bit and clear-slot operations.
- Asynchronous clear on reset.

Test Plan:
All scenarios use NUM_SLOTS=4, MAP_W=8, HASH_W=8.
1. Reset:
- Stimulus: hold in_rst_n=0 for 2 cycles, then release.
- Required: out_hash_ready=1, out_est_valid=0, out_done=0, out_sum=0.
- Stimulus: flush immediately.
- Required: four estimates with slot 0..3, all R=0; out_done pulse with out_sum=0.
2. Rank and wrap:
- Stimulus: hashes 0x01,0x01,0x01,0x01, then 0x02 x4, then flush.
- Required: each bitmap = 0b11, R=2 for slots 0..3, out_sum=8.
- The 5th hash lands in slot 0, which checks pointer wrap.
3. Saturation:
- Stimulus: hash 0x00 then 0x80 to slot 0, then flush.
- Required: bitmap[0] = 0x80, R=0.
- Stimulus: bitmap[1] filled with hashes 0x01,0x02,...,0x80, then flush.
- Required: R=8 for slot 1.
4. Backpressure:
- Stimulus: hold in_est_ready=0 for 3 cycles during slot 1.
- Required: out_est_slot=1 and out_est_r stay stable; out_hash_ready=0 throughout the scan.
- out_done arrives exactly 1 cycle after slot 3 is accepted.
5. Simultaneous events:
- Stimulus: in_flush together with accepted hash 0x04 to slot 0.
- Required: slot 0 reports R=0, and bitmap bit 2 is counted (check through a second hash 0x01 in a later test).
- Stimulus: a second flush during SCAN.
- Required: it is ignored.
6. Reset mid-scan:
- Stimulus: after slot 1 is accepted, assert in_rst_n=0.
- Required: outputs return to reset values immediately, with no out_done.
- Stimulus: flush again.
- Required: all R=0 and ptr restarts at slot 0.
